opcode_prefetch_queue: RTL and testbench
========================================

# opcode_prefetch_queue

Parametrised instruction-prefetch queue for the fetch stage. It streams bytes from the byte-wide RAM port and assembles them into WORD_BYTES-wide opcodes. Completed opcodes are held, each tagged with its fetch address, in a DEPTH-entry FIFO, so decode can consume one opcode per cycle while fetch runs ahead. A flush redirects fetch to a new ip on a branch, discarding queued and partial words.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of ip and RAM address
- WORD_BYTES, 4, bytes per opcode (1..8); opcode width = 8*WORD_BYTES
- DEPTH, 4, FIFO entries (power of two, ≥2)
- BIG_ENDIAN, 1, 1: first fetched byte goes to opcode MSB; 0: to LSB

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- enable  in  1  fetch allowed; while low, no new RAM requests
- ip  in  ADDRESS_WIDTH  start/redirect address, sampled on start or flush
- flush  in  1  one-cycle redirect pulse
- ramData  in  8  RAM read byte, valid in the accept cycle
- ramBusy  in  1  RAM not ready; beat accepted on an edge where request=1 and ramBusy=0
- request  out  1  RAM read request, registered
- address  out  ADDRESS_WIDTH  RAM byte address, held stable while request=1
- opcode  out  8*WORD_BYTES  head-of-queue opcode
- opcodeAddress  out  ADDRESS_WIDTH  address of the first byte of the head opcode
- opcodeValid  out  1  head entry valid
- opcodeReady  in  1  consumer pops the head on an edge with opcodeValid=1 and opcodeReady=1
- level  out  clog2(DEPTH)+1  occupied entries
- busy  out  1  fetch active: state FETCH, or a partial word held

## Operation
- States: IDLE, FETCH, FULL.
- IDLE → FETCH when enable=1: latch address=ip and byteCount=0.
- FETCH: request=1. On each accepted beat:
  - store ramData into byte slot byteCount, ordered per BIG_ENDIAN;
  - address += 1, wrapping mod 2^ADDRESS_WIDTH;
  - byteCount += 1.
- Word completion: on the beat where byteCount reaches WORD_BYTES, push {word, wordStartAddress} into the FIFO and set byteCount=0.
- FETCH → FULL when the push makes the FIFO full; request drops on that edge.
- FULL → FETCH on the edge after a pop frees a slot. request never depends combinationally on opcodeReady.
- FETCH or FULL → IDLE when enable=0 at a word boundary (byteCount=0). A partial word finishes first; request stays high until it does.
- flush=1 has priority over all other events on that edge:
  - FIFO emptied and byteCount=0; a beat accepted on the same edge is discarded;
  - a same-edge pop has no further effect;
  - address=ip, wordStartAddress=ip;
  - next state is FETCH if enable=1, else IDLE.
- Simultaneous push and pop on a full FIFO cannot occur, because no beats are accepted in FULL.
- Simultaneous push and pop otherwise leaves level unchanged.
- FIFO pointers wrap mod DEPTH.

## Timing
- Reset values:
  - request=0, address=0, opcode=0, opcodeAddress=0, opcodeValid=0, level=0, busy=0;
  - state=IDLE, byteCount=0, pointers=0.
- enable sampled at edge N with zero-wait RAM:
  - request=1 after edge N;
  - beats accepted at edges N+1..N+WORD_BYTES;
  - opcodeValid=1 after edge N+WORD_BYTES.
- Sustained throughput: one opcode per WORD_BYTES cycles. Each cycle of ramBusy=1 adds one cycle.
- Pop → level decrements and the next head appears on outputs after the same edge.
- Flush at edge F → opcodeValid=0 after F, request=1 with address=ip after F; first new opcode valid after F+WORD_BYTES.
- Reset deasserting mid-operation resumes from IDLE only; no RAM request is issued while reset=0.

## Structure
- Shared package (fetch_pkg): state enum (IDLE/FETCH/FULL), byte-order constants, and a function for level width.
- Sub-module opcode_fifo: synchronous FIFO, parameters DEPTH and DATA_WIDTH.
  - Payload is {opcodeAddress, opcode}.
  - Outputs are the head entry, full, empty and level; flush is a clear input.
- The top level holds the FSM, byte assembler and address counter.

## Test plan
- Reset, then enable=1 with ip=0x100, zero-wait RAM returning bytes 11,22,33,44 → opcode=0x11223344, opcodeAddress=0x100, valid after edge N+4; with BIG_ENDIAN=0 → 0x44332211.
- opcodeReady=0 with DEPTH=4 → level reaches 4 after 16 beats, request=0, no further beats; one pop → request=1 the next cycle, fetch resumes at 0x110.
- ramBusy=1 for 3 cycles on byte 2 → address held at 0x101, the word completes 3 cycles late, and byte values are unchanged.
- Flush with ip=0x200 while 2 entries are queued and byte 2 is accepting → level=0 and opcodeValid=0 next; the next opcode has opcodeAddress=0x200 and contains no old bytes.
- ip=0xFFFFFFFE → address wraps 0xFFFFFFFF→0x0; opcodeAddress=0xFFFFFFFE, the next word starts at 0x2.
- reset=0 asserted mid-word → all outputs at their reset values immediately, without a clock edge; after release, no request until enable is sampled.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the opcode prefetch queue.
package fetch_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFull
  } fetch_state_e;

  // Byte-order selectors for the BIG_ENDIAN parameter.
  localparam bit LittleEndian = 1'b0;
  localparam bit BigEndian    = 1'b1;

  // Width of an occupancy counter that must be able to hold the value depth.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// Synchronous FIFO holding assembled opcodes and their fetch addresses.
module opcode_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o   = (cnt_q == LvlW'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign level_o  = cnt_q;
  assign rdata_o  = mem_q[rptr_q];
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;

  // Pointer, count and storage update; clear wins over push and pop.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/opcode_prefetch_queue.sv
// Fetch-stage prefetch queue: byte fetch FSM, opcode assembler and opcode FIFO.
module opcode_prefetch_queue import fetch_pkg::*; #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned WORD_BYTES    = 4,
  parameter int unsigned DEPTH         = 4,
  parameter bit          BIG_ENDIAN    = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [ADDRESS_WIDTH-1:0]      ip,
  input  logic                          flush,
  input  logic [7:0]                    ramData,
  input  logic                          ramBusy,
  output logic                          request,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic [8*WORD_BYTES-1:0]       opcode,
  output logic [ADDRESS_WIDTH-1:0]      opcodeAddress,
  output logic                          opcodeValid,
  input  logic                          opcodeReady,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          busy
);

  localparam int unsigned OpW  = 8 * WORD_BYTES;
  localparam int unsigned CntW = 4;
  localparam int unsigned LvlW = level_width(DEPTH);

  fetch_state_e             state_q, state_d;
  logic [CntW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] word_start_q, word_start_d;
  logic [OpW-1:0]           asm_q, asm_d;

  logic                     beat, last_beat, pop;
  logic                     fifo_full, fifo_empty;
  logic [LvlW-1:0]          fifo_level;
  logic [OpW-1:0]           push_word;
  logic [ADDRESS_WIDTH-1:0] push_addr;

  assign request     = (state_q == StFetch);
  assign address     = addr_q;
  assign busy        = request || (byte_cnt_q != '0);
  assign opcodeValid = !fifo_empty;
  assign level       = fifo_level;

  // A beat offered at a word boundary while enable is low is ignored so fetch
  // can stop cleanly; reads have no side effects, so it is simply refetched.
  assign beat      = request && !ramBusy && !flush && (enable || (byte_cnt_q != '0));
  assign last_beat = beat && (byte_cnt_q == CntW'(WORD_BYTES - 1));
  assign pop       = opcodeValid && opcodeReady && !flush;
  // For single-byte words the start address is the current beat address.
  assign push_addr = (byte_cnt_q == '0) ? addr_q : word_start_q;

  // Insert the incoming byte into its slot of the word under assembly.
  always_comb begin
    push_word = asm_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (byte_cnt_q == CntW'((BIG_ENDIAN == BigEndian) ? (WORD_BYTES - 1 - i) : i)) begin
        push_word[i*8 +: 8] = ramData;
      end
    end
  end

  // Next-state logic for the FSM, byte counter and address counter.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    word_start_d = word_start_q;
    asm_d        = asm_q;
    if (flush) begin
      byte_cnt_d   = '0;
      addr_d       = ip;
      word_start_d = ip;
      state_d      = enable ? StFetch : StIdle;
    end else begin
      if (beat) begin
        asm_d      = push_word;
        addr_d     = addr_q + 1'b1;
        byte_cnt_d = last_beat ? '0 : byte_cnt_q + 1'b1;
        if (byte_cnt_q == '0) begin
          word_start_d = addr_q;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            addr_d       = ip;
            word_start_d = ip;
            byte_cnt_d   = '0;
            // Queue may still be full from before fetch was stopped.
            state_d      = fifo_full ? StFull : StFetch;
          end
        end
        StFetch: begin
          if (last_beat && !pop && (fifo_level == LvlW'(DEPTH - 1))) begin
            state_d = StFull;
          end else if (!enable && (byte_cnt_d == '0)) begin
            state_d = StIdle;
          end
        end
        StFull: begin
          if (!enable) begin
            state_d = StIdle;
          end else if (!fifo_full) begin
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      word_start_q <= '0;
      asm_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      word_start_q <= word_start_d;
      asm_q        <= asm_d;
    end
  end

  opcode_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (ADDRESS_WIDTH + OpW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (flush),
    .push_i  (last_beat),
    .wdata_i ({push_addr, push_word}),
    .pop_i   (pop),
    .rdata_o ({opcodeAddress, opcode}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_opcode_prefetch_queue.sv
// Directed bench for opcode_prefetch_queue: table-driven fill plus corner sequences.
module tb_opcode_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, enable, flush, ramBusy, opcodeReady;
  logic [31:0] ip;
  logic [7:0]  ramData;

  logic        request, opcodeValid, busy;
  logic [31:0] address, opcode, opcodeAddress;
  logic [2:0]  level;

  logic        le_request, le_valid, le_busy;
  logic [31:0] le_address, le_opcode, le_opaddr;
  logic [2:0]  le_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  opcode_prefetch_queue #(
    .ADDRESS_WIDTH (32),
    .WORD_BYTES    (4),
    .DEPTH         (4),
    .BIG_ENDIAN    (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ip            (ip),
    .flush         (flush),
    .ramData       (ramData),
    .ramBusy       (ramBusy),
    .request       (request),
    .address       (address),
    .opcode        (opcode),
    .opcodeAddress (opcodeAddress),
    .opcodeValid   (opcodeValid),
    .opcodeReady   (opcodeReady),
    .level         (level),
    .busy          (busy)
  );

  // Little-endian twin running in lockstep on the same byte stream.
  opcode_prefetch_queue #(
    .ADDRESS_WIDTH (32),
    .WORD_BYTES    (4),
    .DEPTH         (4),
    .BIG_ENDIAN    (1'b0)
  ) dut_le (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ip            (ip),
    .flush         (flush),
    .ramData       (ramData),
    .ramBusy       (ramBusy),
    .request       (le_request),
    .address       (le_address),
    .opcode        (le_opcode),
    .opcodeAddress (le_opaddr),
    .opcodeValid   (le_valid),
    .opcodeReady   (opcodeReady),
    .level         (le_level),
    .busy          (le_busy)
  );

  // RAM contents: 0x100.. reads 11,22,33,44,...; the page nibble shifts the pattern.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    int v;
    v = 17 * (int'(a[3:0]) + 1) + int'(a[11:8]) - 1;
    return v[7:0];
  endfunction

  assign ramData = ram_byte(address);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ticks;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  lvl;
    logic        vld;
    logic        bsy;
    logic [31:0] op_be;
    logic [31:0] op_le;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    flush       = 1'b0;
    ramBusy     = 1'b0;
    opcodeReady = 1'b0;
    ip          = 32'h0;

    // Reset values.
    tick(2);
    check("rst_request", 64'(request), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    check("rst_opaddr", 64'(opcodeAddress), 64'd0);
    check("rst_valid", 64'(opcodeValid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick(1);
    check("idle_no_request", 64'(request), 64'd0);

    // Fill from 0x100 with the consumer stalled.
    vecs[0] = '{1, 1'b1, 32'h100, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{1, 1'b1, 32'h101, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[2] = '{2, 1'b1, 32'h103, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1, 1'b1, 32'h104, 3'd1, 1'b1, 1'b1, 32'h11223344, 32'h44332211};
    vecs[4] = '{4, 1'b1, 32'h108, 3'd2, 1'b1, 1'b1, 32'h11223344, 32'h44332211};
    vecs[5] = '{7, 1'b1, 32'h10F, 3'd3, 1'b1, 1'b1, 32'h11223344, 32'h44332211};
    vecs[6] = '{1, 1'b0, 32'h110, 3'd4, 1'b1, 1'b0, 32'h11223344, 32'h44332211};
    vecs[7] = '{2, 1'b0, 32'h110, 3'd4, 1'b1, 1'b0, 32'h11223344, 32'h44332211};
    enable = 1'b1;
    ip     = 32'h100;
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].ticks);
      check($sformatf("vec%0d_request", i), 64'(request), 64'(vecs[i].req));
      check($sformatf("vec%0d_address", i), 64'(address), 64'(vecs[i].addr));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].lvl));
      check($sformatf("vec%0d_valid", i), 64'(opcodeValid), 64'(vecs[i].vld));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
      check($sformatf("vec%0d_le_status", i),
            64'({le_request, le_valid, le_busy, le_level, le_address}),
            64'({vecs[i].req, vecs[i].vld, vecs[i].bsy, vecs[i].lvl, vecs[i].addr}));
      if (vecs[i].vld) begin
        check($sformatf("vec%0d_opcode_be", i), 64'(opcode), 64'(vecs[i].op_be));
        check($sformatf("vec%0d_opcode_le", i), 64'(le_opcode), 64'(vecs[i].op_le));
        check($sformatf("vec%0d_opaddr", i), 64'({le_opaddr, opcodeAddress}), {32'h100, 32'h100});
      end
    end

    // One pop from a full queue: fetch resumes one cycle later at 0x110.
    opcodeReady = 1'b1;
    tick(1);
    opcodeReady = 1'b0;
    check("pop_level", 64'(level), 64'd3);
    check("pop_request_low", 64'(request), 64'd0);
    check("pop_head_opcode", 64'(opcode), 64'h55667788);
    check("pop_head_opaddr", 64'(opcodeAddress), 64'h104);
    tick(1);
    check("resume_request", 64'(request), 64'd1);
    check("resume_address", 64'(address), 64'h110);
    tick(4);
    check("refill_level", 64'(level), 64'd4);
    check("refill_request", 64'(request), 64'd0);
    check("refill_address", 64'(address), 64'h114);

    // Flush back to 0x100 and stall the second byte for three cycles.
    flush = 1'b1;
    ip    = 32'h100;
    tick(1);
    flush = 1'b0;
    check("flush1_level", 64'(level), 64'd0);
    check("flush1_valid", 64'(opcodeValid), 64'd0);
    check("flush1_request", 64'(request), 64'd1);
    check("flush1_address", 64'(address), 64'h100);
    tick(1);
    ramBusy = 1'b1;
    tick(3);
    check("stall_address", 64'(address), 64'h101);
    check("stall_request", 64'(request), 64'd1);
    ramBusy = 1'b0;
    tick(2);
    check("stall_late_level", 64'(level), 64'd0);
    tick(1);
    check("stall_done_level", 64'(level), 64'd1);
    check("stall_done_opcode", 64'(opcode), 64'h11223344);
    check("stall_done_address", 64'(address), 64'h104);

    // Flush to 0x200 with two entries queued and the second byte being accepted.
    tick(4);
    check("pre_flush_level", 64'(level), 64'd2);
    tick(1);
    check("pre_flush_address", 64'(address), 64'h109);
    flush = 1'b1;
    ip    = 32'h200;
    tick(1);
    flush = 1'b0;
    check("flush2_level", 64'(level), 64'd0);
    check("flush2_valid", 64'(opcodeValid), 64'd0);
    check("flush2_request", 64'(request), 64'd1);
    check("flush2_address", 64'(address), 64'h200);
    tick(3);
    check("flush2_pending_level", 64'(level), 64'd0);
    tick(1);
    check("flush2_word_level", 64'(level), 64'd1);
    check("flush2_word_opaddr", 64'(opcodeAddress), 64'h200);
    check("flush2_word_opcode", 64'(opcode), 64'h12233445);

    // Address wrap from 0xFFFFFFFE.
    flush = 1'b1;
    ip    = 32'hFFFF_FFFE;
    tick(1);
    flush = 1'b0;
    check("wrap_start_address", 64'(address), 64'hFFFF_FFFE);
    tick(2);
    check("wrap_address", 64'(address), 64'h0);
    tick(2);
    check("wrap_level", 64'(level), 64'd1);
    check("wrap_opaddr", 64'(opcodeAddress), 64'hFFFF_FFFE);
    check("wrap_opcode", 64'(opcode), 64'h0D1E1021);
    // Pop on the edge that pushes the second word: level holds at one.
    tick(3);
    opcodeReady = 1'b1;
    tick(1);
    opcodeReady = 1'b0;
    check("pushpop_level", 64'(level), 64'd1);
    check("wrap_next_opaddr", 64'(opcodeAddress), 64'h2);
    check("wrap_next_opcode", 64'(opcode), 64'h32435465);

    // Enable low at a word boundary stops fetch at once.
    enable = 1'b0;
    tick(1);
    check("stop_request", 64'(request), 64'd0);
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_level", 64'(level), 64'd1);
    enable = 1'b1;
    ip     = 32'h300;
    tick(1);
    check("restart_request", 64'(request), 64'd1);
    check("restart_address", 64'(address), 64'h300);

    // Asynchronous reset mid-word, away from any clock edge.
    tick(6);
    check("pre_reset_level", 64'(level), 64'd2);
    reset = 1'b0;
    #1;
    check("async_request", 64'(request), 64'd0);
    check("async_address", 64'(address), 64'd0);
    check("async_opcode", 64'(opcode), 64'd0);
    check("async_opaddr", 64'(opcodeAddress), 64'd0);
    check("async_valid", 64'(opcodeValid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    #1;
    reset = 1'b1;
    tick(2);
    check("post_reset_request", 64'(request), 64'd0);
    enable = 1'b1;
    ip     = 32'h100;
    tick(1);
    check("post_reset_fetch", 64'({request, address}), {31'd0, 1'b1, 32'h100});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
